// File: rtl/dense_param_loader.sv
// dense_param_loader
// Takes a byte stream of signed 8-bit parameters and writes each one as an exact
// IEEE-754 single-precision value into the bias bus and then the weight bus of
// one dense layer. params_valid marks a complete, consistent parameter set.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | after reset, nothing loaded yet, waiting for start
// LOAD_BIAS   | accepting NB_NEURONS bias bytes
// LOAD_WEIGHT | accepting NB_INPUT*NB_NEURONS weight bytes
// FLUSH       | stream closed, last pending conversion lands this cycle
// DONE        | buses complete, params_valid high until the next start

module dense_param_loader #(
    parameter int FLOAT      = 32,
    parameter int NB_INPUT   = 42,
    parameter int NB_NEURONS = 24
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic                               s_valid,
    output logic                               s_ready,
    input  logic [7:0]                         s_data,
    output logic [NB_NEURONS*FLOAT-1:0]        bias_bus,
    output logic [NB_INPUT*NB_NEURONS*FLOAT-1:0] weight_bus,
    output logic                               params_valid,
    output logic                               busy
);

    localparam int NB_W   = NB_INPUT * NB_NEURONS;
    localparam int BCNT_W = (NB_NEURONS > 1) ? $clog2(NB_NEURONS) : 1;
    localparam int WCNT_W = (NB_W > 1) ? $clog2(NB_W) : 1;
    localparam int IDX_W  = (BCNT_W > WCNT_W) ? BCNT_W : WCNT_W;

    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(NB_NEURONS - 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(NB_W - 1);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        LOAD_BIAS   = 3'd1,
        LOAD_WEIGHT = 3'd2,
        FLUSH       = 3'd3,
        DONE        = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic               pend_v_q, pend_v_d;
    logic               pend_bias_q, pend_bias_d;
    logic [IDX_W-1:0]   pend_idx_q, pend_idx_d;
    logic [7:0]         pend_byte_q, pend_byte_d;
    logic [NB_NEURONS*FLOAT-1:0] bias_q, bias_d;
    logic [NB_W*FLOAT-1:0]       weight_q, weight_d;
    logic [FLOAT-1:0]            conv_word;
    logic                        hs;

    // Exact int8 -> float32: every int8 fits the 24-bit significand, so no rounding.
    function automatic logic [31:0] to_f32(input logic [7:0] x);
        logic [7:0]  m;
        logic [2:0]  p;
        logic [31:0] sh;
        m = x[7] ? (~x + 8'd1) : x;
        p = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) p = 3'(i);
        end
        sh = {24'd0, m} << (5'd23 - {2'b00, p});
        if (m == 8'd0) to_f32 = 32'd0;
        else           to_f32 = {x[7], 8'd127 + {5'd0, p}, sh[22:0]};
    endfunction

    // State register and stream-side bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bcnt_q      <= '0;
            wcnt_q      <= '0;
            pend_v_q    <= 1'b0;
            pend_bias_q <= 1'b0;
            pend_idx_q  <= '0;
            pend_byte_q <= '0;
        end else begin
            state_q     <= state_d;
            bcnt_q      <= bcnt_d;
            wcnt_q      <= wcnt_d;
            pend_v_q    <= pend_v_d;
            pend_bias_q <= pend_bias_d;
            pend_idx_q  <= pend_idx_d;
            pend_byte_q <= pend_byte_d;
        end
    end

    // Next state, counters and capture of the accepted byte; start overrides a handshake
    always_comb begin
        state_d     = state_q;
        bcnt_d      = bcnt_q;
        wcnt_d      = wcnt_q;
        pend_v_d    = 1'b0;
        pend_bias_d = pend_bias_q;
        pend_idx_d  = pend_idx_q;
        pend_byte_d = pend_byte_q;
        hs          = s_valid && s_ready;
        if (start) begin
            state_d = LOAD_BIAS;
            bcnt_d  = '0;
            wcnt_d  = '0;
        end else begin
            case (state_q)
                LOAD_BIAS: begin
                    if (hs) begin
                        pend_v_d    = 1'b1;
                        pend_bias_d = 1'b1;
                        pend_idx_d  = IDX_W'(bcnt_q);
                        pend_byte_d = s_data;
                        bcnt_d      = bcnt_q + 1'b1;
                        if (bcnt_q == BCNT_LAST) state_d = LOAD_WEIGHT;
                    end
                end
                LOAD_WEIGHT: begin
                    if (hs) begin
                        pend_v_d    = 1'b1;
                        pend_bias_d = 1'b0;
                        pend_idx_d  = IDX_W'(wcnt_q);
                        pend_byte_d = s_data;
                        wcnt_d      = wcnt_q + 1'b1;
                        if (wcnt_q == WCNT_LAST) state_d = FLUSH;
                    end
                end
                FLUSH:   state_d = DONE;
                default: state_d = state_q;
            endcase
        end
    end

    // Status outputs are pure functions of state so s_ready never waits on s_valid
    always_comb begin
        s_ready      = 1'b0;
        busy         = 1'b0;
        params_valid = 1'b0;
        case (state_q)
            LOAD_BIAS, LOAD_WEIGHT: begin
                s_ready = 1'b1;
                busy    = 1'b1;
            end
            FLUSH:   busy = 1'b1;
            DONE:    params_valid = 1'b1;
            default: ;
        endcase
    end

    // Converted word lands in its slot one cycle after the handshake; other slots hold
    always_comb begin
        bias_d    = bias_q;
        weight_d  = weight_q;
        conv_word = to_f32(pend_byte_q);
        if (pend_v_q) begin
            if (pend_bias_q) bias_d[int'(pend_idx_q)*FLOAT +: FLOAT]   = conv_word;
            else             weight_d[int'(pend_idx_q)*FLOAT +: FLOAT] = conv_word;
        end
    end

    // Parameter bus storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bias_q   <= '0;
            weight_q <= '0;
        end else begin
            bias_q   <= bias_d;
            weight_q <= weight_d;
        end
    end

    assign bias_bus   = bias_q;
    assign weight_bus = weight_q;

endmodule
